// File: rtl/decode_stage.sv
// RV32I decode stage: hands rs1/rs2 to a registered-read register file, waits out its latency,
// and issues a decoded bundle to execute while a busy scoreboard blocks reads of pending writes.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [REG_AW-1:0] rf_a1,
    output logic [REG_AW-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1_val,
    output logic [DATA_W-1:0] out_rs2_val,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic              out_we,
    output logic              out_illegal
);

    // state | meaning
    // IDLE  | ready for a new instruction
    // CHECK | addresses on rf_a1/rf_a2, waiting for sources to be non-busy
    // READ  | register file data valid this cycle
    // OUT   | bundle presented to execute, held until out_ready
    typedef enum logic [1:0] {IDLE, CHECK, READ, OUT} state_t;

    state_t                  state;
    logic [31:0]             instr_q;
    logic [DATA_W-1:0]       pc_q;
    logic [2**REG_AW-1:0]    busy;
    logic [2**REG_AW-1:0]    busy_next;
    logic [REG_AW-1:0]       rs1, rs2, rd;
    logic [6:0]              opcode;
    logic                    uses_rs1, uses_rs2, we_dec, illegal, rd_we, hazard;
    logic signed [31:0]      imm32;

    assign opcode = instr_q[6:0];
    assign rs1    = instr_q[15 +: REG_AW];
    assign rs2    = instr_q[20 +: REG_AW];
    assign rd     = instr_q[7 +: REG_AW];

    assign in_ready = rst_n && (state == IDLE);
    assign rf_a1    = (state == IDLE) ? '0 : rs1;
    assign rf_a2    = (state == IDLE) ? '0 : rs2;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        we_dec   = 1'b0;
        illegal  = 1'b0;
        imm32    = '0;
        case (opcode)
            7'b0110011: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; we_dec = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                uses_rs1 = 1'b1; we_dec = 1'b1;
                imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            end
            7'b0100011: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            end
            7'b1100011: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                         instr_q[11:8], 1'b0};
            end
            7'b1101111: begin
                we_dec = 1'b1;
                imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                         instr_q[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                we_dec = 1'b1;
                imm32 = {instr_q[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd_we  = we_dec && (rd != '0);
    assign hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]);

    // Set is applied after clear so a same-edge retire cannot drop a freshly issued write.
    always_comb begin
        busy_next = busy;
        if (wb_valid && (wb_rd != '0)) busy_next[wb_rd] = 1'b0;
        if ((state == READ) && rd_we)  busy_next[rd]    = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rd      <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            busy <= busy_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        pc_q    <= in_pc;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) state <= READ;
                end
                READ: begin
                    out_valid   <= 1'b1;
                    out_rs1_val <= uses_rs1 ? rf_rd1 : '0;
                    out_rs2_val <= uses_rs2 ? rf_rd2 : '0;
                    out_imm     <= DATA_W'(imm32);
                    out_pc      <= pc_q;
                    out_rd      <= rd;
                    out_opcode  <= opcode;
                    out_funct3  <= instr_q[14:12];
                    out_funct7  <= instr_q[31:25];
                    out_we      <= rd_we;
                    out_illegal <= illegal;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: bench-owned register file, scoreboard model and arithmetic immediate model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_we, out_illegal;

    logic [31:0] regs [32];
    bit   [31:0] sb;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_pc(out_pc), .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_we(out_we), .out_illegal(out_illegal)
    );

    // Register file with one-edge registered read; same-edge read returns the old value.
    always @(posedge clk) begin
        rf_rd1 <= (rf_a1 == 5'd0) ? 32'd0 : regs[rf_a1];
        rf_rd2 <= (rf_a2 == 5'd0) ? 32'd0 : regs[rf_a2];
        if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end

    function automatic logic [31:0] rval(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    function automatic void ref_decode(input logic [31:0] i, output bit u1, output bit u2,
                                       output bit we, output bit ill, output logic [31:0] imm);
        int v;
        u1 = 0; u2 = 0; we = 0; ill = 0; v = 0;
        case (i[6:0])
            7'h33: begin u1 = 1; u2 = 1; we = 1; end
            7'h13, 7'h03, 7'h67: begin
                u1 = 1; we = 1;
                v = int'(i[31:20]) - (i[31] ? 4096 : 0);
            end
            7'h23: begin
                u1 = 1; u2 = 1;
                v = int'(i[31:25]) * 32 + int'(i[11:7]) - (i[31] ? 4096 : 0);
            end
            7'h63: begin
                u1 = 1; u2 = 1;
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2
                    - (i[31] ? 4096 : 0);
            end
            7'h6F: begin
                we = 1;
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                    - (i[31] ? 1048576 : 0);
            end
            7'h37, 7'h17: begin
                we = 1;
                v = int'(i & 32'hFFFFF000);
            end
            default: ill = 1;
        endcase
        imm = 32'(v);
    endfunction

    task automatic do_wb(input logic [4:0] r, input logic [31:0] val);
        wb_valid = 1'b1; wb_rd = r; wb_data = val;
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
        if (r != 5'd0) sb[r] = 1'b0;
    endtask

    // Issues one instruction, resolves predicted stalls with writebacks, checks the bundle,
    // holds out_ready low for 'hold' cycles, then retires it. 'clash' retires rd at the issue edge.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] pc,
                             input int hold, input bit clash);
        bit u1, u2, we, ill, haz;
        logic [31:0]  imm, v1, v2;
        logic [4:0]   rs1, rs2, rd;
        logic [151:0] exp_b, got_b;
        int n;
        rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
        ref_decode(ins, u1, u2, we, ill, imm);
        haz = (u1 && sb[rs1]) || (u2 && sb[rs2]);

        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;

        n_tests++;
        if (rf_a1 !== rs1 || rf_a2 !== rs2) begin
            n_fail++;
            $display("FAIL rf_addr: got a1=%0d a2=%0d required a1=%0d a2=%0d", rf_a1, rf_a2, rs1, rs2);
        end

        if (haz) begin
            n = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); @(negedge clk);
                if (out_valid !== 1'b0) n++;
            end
            n_tests++;
            if (n != 0) begin
                n_fail++; $display("FAIL stall: out_valid high %0d cycles required 0", n);
            end
            if (u1 && sb[rs1]) do_wb(rs1, $urandom);
            if (u2 && sb[rs2]) do_wb(rs2, $urandom);
        end
        @(posedge clk); @(negedge clk);
        v1 = u1 ? rval(rs1) : 32'd0;
        v2 = u2 ? rval(rs2) : 32'd0;
        if (clash) begin wb_valid = 1'b1; wb_rd = rd; wb_data = $urandom; end
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;

        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL latency: out_valid=%b required 1", out_valid);
            n = 0;
            while (out_valid !== 1'b1 && n < 30) begin @(posedge clk); @(negedge clk); n++; end
        end
        if (we && rd != 5'd0) sb[rd] = 1'b1;

        exp_b = {v1, v2, imm, pc, rd, ins[6:0], ins[14:12], ins[31:25], (we && rd != 5'd0), ill};
        got_b = {out_rs1_val, out_rs2_val, out_imm, out_pc, out_rd, out_opcode, out_funct3,
                 out_funct7, out_we, out_illegal};
        n_tests++;
        if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL bundle ins=%h: got %h required %h", ins, got_b, exp_b);
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            got_b = {out_rs1_val, out_rs2_val, out_imm, out_pc, out_rd, out_opcode, out_funct3,
                     out_funct7, out_we, out_illegal};
            n_tests++;
            if (got_b !== exp_b || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: valid=%b ready=%b bundle %h required %h",
                         h, out_valid, in_ready, got_b, exp_b);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL retire: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_a1 !== 5'd0 || rf_a2 !== 5'd0 ||
            {out_rs1_val, out_rs2_val, out_imm, out_pc, out_rd, out_opcode, out_funct3,
             out_funct7, out_we, out_illegal} !== 152'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b a1=%0d a2=%0d imm=%h", out_valid,
                     in_ready, rf_a1, rf_a2, out_imm);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        sb = '0;
    endtask

    task automatic test_load_regs;
        for (int r = 1; r < 32; r++) do_wb(5'(r), $urandom);
        do_wb(5'd1, 32'd5);
        do_wb(5'd2, 32'd7);
    endtask

    task automatic test_add;
        run_instr(32'h002081B3, 32'h0000_1000, 0, 1'b0);
    endtask

    task automatic test_hazard;
        run_instr(32'h00118213, 32'h0000_1004, 0, 1'b0);
    endtask

    task automatic test_imm_hold;
        run_instr(32'hFFF00293, 32'h0000_1008, 5, 1'b0);
    endtask

    task automatic test_branch_illegal;
        run_instr(32'hFE208CE3, 32'h0000_100C, 0, 1'b0);
        run_instr(32'h0000037F, 32'h0000_1010, 1, 1'b0);
    endtask

    task automatic test_set_wins;
        run_instr(32'h00100313, 32'h0000_1014, 0, 1'b1);
        run_instr(32'h00030393, 32'h0000_1018, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_instr(32'h002081B3, 32'h0000_2000, 0, 1'b0);
        in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 32'h0000_2004;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b out_we=%b required 0/0/0",
                     out_valid, in_ready, out_we);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_ready: in_ready=%b required 1", in_ready);
        end
        sb = '0;
        run_instr(32'h00118213, 32'h0000_2008, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [6:0]  opcs [10];
        logic [31:0] ins, r;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};
        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            ins = {r[31:7], opcs[$urandom_range(0, 9)]};
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            run_instr(ins, $urandom, $urandom_range(0, 2), 1'b0);
            if ($urandom_range(0, 1) == 1) do_wb(5'($urandom_range(1, 7)), $urandom);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        out_ready = 1'b0; sb = '0;
        test_reset();
        test_load_regs();
        test_add();
        test_hazard();
        test_imm_hold();
        test_branch_illegal();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage sitting directly upstream of register_file.
- Accepts a fetched RV32I instruction over a valid/ready handshake and drives the register-file read addresses (rf_a1, rf_a2).
- Waits out the register file's one-cycle registered read latency, then presents a decoded bundle (operands, immediate, rd, control fields) to execute.
- Holds a per-register busy scoreboard so that no source is read while an older instruction's write to it is still pending.

Parameters:
- DATA_W, 32, data, PC and immediate width.
- REG_AW, 5, register address width (2**REG_AW registers; x0 hardwired zero).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  stage accepts the instruction.
- in_instr  input  32  instruction word.
- in_pc  input  DATA_W  PC of the instruction.
- rf_a1  output  REG_AW  register file read address 1 (rs1).
- rf_a2  output  REG_AW  register file read address 2 (rs2).
- rf_rd1  input  DATA_W  register file read data 1, registered one edge after rf_a1.
- rf_rd2  input  DATA_W  register file read data 2, registered one edge after rf_a2.
- wb_valid  input  1  writeback retires a write this cycle.
- wb_rd  input  REG_AW  destination of the retiring write.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_rs1_val  output  DATA_W  rs1 operand.
- out_rs2_val  output  DATA_W  rs2 operand.
- out_imm  output  DATA_W  sign-extended immediate.
- out_pc  output  DATA_W  PC passthrough.
- out_rd  output  REG_AW  destination register.
- out_opcode  output  7  instr[6:0].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25].
- out_we  output  1  instruction writes rd (forced 0 when rd==0).
- out_illegal  output  1  unrecognised opcode.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE; busy[] cleared.
  - All out_* registers 0; out_valid=0.
  - rf_a1=rf_a2=0; in_ready=0 during reset, 1 after.
  - Reset mid-operation discards the in-flight instruction.
- FSM IDLE:
  - in_ready=1.
  - On in_valid, latch in_instr and in_pc, then go to CHECK.
- FSM CHECK:
  - rf_a1/rf_a2 driven combinationally from the latched rs1/rs2 (instr[19:15], instr[24:20]) in every state except IDLE.
  - hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]).
  - If hazard, stay in CHECK; else go to READ.
  - The register file samples the addresses at the CHECK→READ edge.
- FSM READ:
  - rf_rd1/rf_rd2 are valid.
  - At the next edge: capture operands and the decode into the out_* registers, set out_valid=1, and go to OUT.
  - Unused source operand is captured as 0.
- FSM OUT:
  - Hold all out_* stable while out_valid & !out_ready.
  - On out_ready: clear out_valid at the edge and go to IDLE.
- Latency: accept→out_valid is 3 edges with no hazard. Throughput is 1 instruction per 4 cycles.
- Decode by opcode (uses_rs1/uses_rs2/we, imm):
  - R 0110011: 1/1/1, imm 0.
  - I-ALU 0010011 and LOAD 0000011: 1/0/1, I-imm.
  - JALR 1100111: 1/0/1, I-imm.
  - STORE 0100011: 1/1/0, S-imm.
  - BRANCH 1100011: 1/1/0, B-imm (bit0=0).
  - JAL 1101111: 0/0/1, J-imm (bit0=0).
  - LUI 0110111 and AUIPC 0010111: 0/0/1, U-imm (low 12 bits 0).
  - Any other opcode: out_illegal=1, uses=0/0, we=0, imm 0. It still flows through the pipeline without stalling.
- Scoreboard:
  - At the READ→OUT edge, if out_we, set busy[rd].
  - An edge with wb_valid & wb_rd!=0 clears busy[wb_rd].
  - Same-edge set and clear of the same register: set wins.
  - busy[0] is always 0.
  - The hazard check uses registered busy. A source is therefore read no earlier than the edge after its clear. This is mandatory because the register file returns the pre-write value when a read and a write hit the same edge.
- wb_valid for a register that is not busy: clears nothing harmful; no error is raised.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with regfile x1=5, x2=7 → rf_a1=1, rf_a2=2; out_valid 3 edges after accept; rs1_val=5, rs2_val=7, rd=3, we=1; busy[3]=1.
- ADDI x5,x0,-1 (0xFFF00293) → imm=0xFFFFFFFF, rs1_val=0, rs2_val=0, we=1.
- ADD x3 followed by ADDI x4,x3,1 → second instruction stalls in CHECK until the edge after wb_valid with wb_rd=3; then rs1_val equals the value written.
- out_ready held low 5 cycles with out_valid=1 → all out_* stable and in_ready=0; release → IDLE and next instruction accepted.
- BEQ x1,x2,-8 (0xFE208CE3) → imm=0xFFFFFFF8, we=0, no busy set. Opcode 0x7F → out_illegal=1, we=0.
- rst_n low while in READ with busy[3] set → next cycle out_valid=0, busy cleared, in_ready=1 after reset.
